tank_level_encoder: RTL and testbench

Sensor-side encoder for the water-tank level display. Samples two raw level-probe inputs, synchronises and debounces them, and classifies the tank state. Detects a persistent inconsistent probe combination as a sensor fault. Drives the registered 2-bit status code consumed by the seven-segment decoder (00 "A", 01 "n", 10 "b", 11 "d"), plus a change strobe and a transition counter for the LEDs.

---
 rtl/tank_level_encoder.sv | 142 ++++++++++++++
 tb/tb_tank_level_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tank_level_encoder.sv
// tank_level_encoder: synchronises and debounces two tank-level probes,
// classifies the tank state into a 2-bit display code and reports faults
// and status transitions.
// Build option: define FAULT_LATCH_EN to make the fault indicator sticky
// until clear_fault is asserted; otherwise fault follows the fault
// condition and clear_fault has no effect.
module tank_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_CYCLES    = 8
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       sensor_hi,
  input  logic       sensor_lo,
  input  logic       clear_fault,
  output logic [1:0] status,
  output logic       valid,
  output logic       changed,
  output logic       fault,
  output logic [7:0] change_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FLT_W = $clog2(FAULT_CYCLES + 1);
  localparam int VLD_W = $clog2(DEBOUNCE_CYCLES + 2);

  localparam logic [1:0] ST_FULL   = 2'b00;
  localparam logic [1:0] ST_MID    = 2'b01;
  localparam logic [1:0] ST_LOW    = 2'b10;
  localparam logic [1:0] ST_FAULTY = 2'b11;

  // Bit 1 carries the high probe, bit 0 the low probe.
  logic [1:0]            sync_p0;
  logic [1:0]            sync_p1;
  logic [1:0]            lvl_p2;
  logic [1:0][DB_W-1:0]  db_cnt;

  logic [FLT_W-1:0]      flt_cnt;
  logic [FLT_W-1:0]      flt_cnt_next;
  logic                  inconsistent;
  logic                  fault_cond;

  logic [VLD_W-1:0]      vld_cnt;
  logic [1:0]            status_next;

  // Maps the debounced probe pair to a display code; the impossible
  // combination (high wet, low dry) keeps the previous code.
  function automatic logic [1:0] classify(input logic hi, input logic lo,
                                          input logic [1:0] hold);
    logic [1:0] code;
    code = hold;
    if (hi && lo)        code = ST_FULL;
    else if (!hi && lo)  code = ST_MID;
    else if (!hi && !lo) code = ST_LOW;
    return code;
  endfunction

  // Stage p0/p1: two-flop synchroniser for both raw probes.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {sensor_hi, sensor_lo};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-probe debounce; a new level is accepted only after an
  // unbroken run of DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      lvl_p2 <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fault persistence count and next status. The fault condition is taken
  // from the next count so fault rises on the edge the count saturates.
  always_comb begin
    inconsistent = lvl_p2[1] & ~lvl_p2[0];
    flt_cnt_next = '0;
    if (inconsistent) begin
      if (flt_cnt == FLT_W'(FAULT_CYCLES)) flt_cnt_next = flt_cnt;
      else                                 flt_cnt_next = flt_cnt + 1'b1;
    end
    fault_cond  = (flt_cnt_next == FLT_W'(FAULT_CYCLES));
    status_next = fault ? ST_FAULTY : classify(lvl_p2[1], lvl_p2[0], status);
  end

`ifndef FAULT_LATCH_EN
  logic unused_clear_fault;
  assign unused_clear_fault = clear_fault;
`endif

  // Fault counter and fault indicator register.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      flt_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      flt_cnt <= flt_cnt_next;
`ifdef FAULT_LATCH_EN
      if (fault_cond)       fault <= 1'b1;
      else if (clear_fault) fault <= 1'b0;
`else
      fault <= fault_cond;
`endif
    end
  end

  // Output stage: status register, start-up valid delay and change reporting.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      status       <= ST_LOW;
      valid        <= 1'b0;
      vld_cnt      <= '0;
      changed      <= 1'b0;
      change_count <= '0;
    end else begin
      status <= status_next;
      if (!valid) begin
        vld_cnt <= vld_cnt + 1'b1;
        if (vld_cnt == VLD_W'(DEBOUNCE_CYCLES + 1)) valid <= 1'b1;
      end
      changed <= valid && (status_next != status);
      if (valid && (status_next != status)) change_count <= change_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tank_level_encoder.sv
// Testbench for tank_level_encoder: directed scenarios plus randomized probe
// activity, compared every cycle against a history-based reference model.
module tb_tank_level_encoder;

  localparam int D = 4;
  localparam int F = 8;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       sensor_hi = 1'b0;
  logic       sensor_lo = 1'b0;
  logic       clear_fault = 1'b0;
  logic [1:0] status;
  logic       valid;
  logic       changed;
  logic       fault;
  logic [7:0] change_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_2 = ~clk_2;

  tank_level_encoder #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
    .clk_2(clk_2), .reset(reset), .sensor_hi(sensor_hi), .sensor_lo(sensor_lo),
    .clear_fault(clear_fault), .status(status), .valid(valid), .changed(changed),
    .fault(fault), .change_count(change_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw probe history (rh/rl, entry k-1 = value seen at
  // edge k) and debounced history (dh/dl, entry k = level after edge k).
  bit rh[$], rl[$], dh[$], dl[$];
  int n;
  int m_status, m_valid, m_changed, m_fault, m_count;

  function automatic bit synced_sample(input bit is_hi, input int e);
    if (e < 3) return 1'b0;
    return is_hi ? rh[e-3] : rl[e-3];
  endfunction

  task automatic model_reset();
    rh.delete(); rl.delete(); dh.delete(); dl.delete();
    dh.push_back(1'b0); dl.push_back(1'b0);
    n = 0;
    m_status = 2; m_valid = 0; m_changed = 0; m_fault = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit hi, input bit lo, input bit clr);
    bit pre_h, pre_l, acc_h, acc_l, cond;
    int new_status;
    n++;
    rh.push_back(hi); rl.push_back(lo);
    pre_h = dh[n-1]; pre_l = dl[n-1];
    // A level flips once the last D synchronised samples all disagree with it.
    acc_h = 1'b1; acc_l = 1'b1;
    for (int j = 0; j < D; j++) begin
      if (synced_sample(1'b1, n - j) == pre_h) acc_h = 1'b0;
      if (synced_sample(1'b0, n - j) == pre_l) acc_l = 1'b0;
    end
    dh.push_back(acc_h ? !pre_h : pre_h);
    dl.push_back(acc_l ? !pre_l : pre_l);
    // Fault condition: the last F pre-edge debounced pairs all inconsistent.
    cond = 1'b1;
    for (int j = 0; j < F; j++) begin
      int k;
      k = n - 1 - j;
      if (k < 0) cond = 1'b0;
      else if (!(dh[k] && !dl[k])) cond = 1'b0;
    end
    if (m_fault != 0)          new_status = 3;
    else if (pre_h && !pre_l)  new_status = m_status;
    else if (pre_h)            new_status = 0;
    else if (pre_l)            new_status = 1;
    else                       new_status = 2;
    m_changed = (m_valid != 0 && new_status != m_status) ? 1 : 0;
    if (m_changed != 0) m_count = (m_count + 1) % 256;
    m_status = new_status;
`ifdef FAULT_LATCH_EN
    if (cond) m_fault = 1;
    else if (clr) m_fault = 0;
`else
    m_fault = cond ? 1 : 0;
`endif
    m_valid = (n >= D + 2) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("status", int'(status), m_status);
    check("valid", int'(valid), m_valid);
    check("changed", int'(changed), m_changed);
    check("fault", int'(fault), m_fault);
    check("change_count", int'(change_count), m_count);
  endtask

  task automatic cycle(input bit hi, input bit lo, input bit clr);
    sensor_hi = hi; sensor_lo = lo; clear_fault = clr;
    @(posedge clk_2);
    model_edge(hi, lo, clr);
    #1;
    compare_all();
  endtask

  task automatic hold(input bit hi, input bit lo, input bit clr, input int k);
    for (int i = 0; i < k; i++) cycle(hi, lo, clr);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic apply_reset();
    sensor_hi = 1'b0; sensor_lo = 1'b0; clear_fault = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_status", int'(status), 2);
    check("rst_valid", int'(valid), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_count", int'(change_count), 0);
    @(posedge clk_2);
    @(posedge clk_2);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2;
    apply_reset();

    // Idle after reset: valid delay, status stays low.
    hold(0, 0, 0, 12);
    check("idle_status", int'(status), 2);

    // Rising water: low probe, then high probe.
    hold(0, 1, 0, 20);
    hold(1, 1, 0, 20);
    check("rise_count", int'(change_count), 2);
    check("rise_status", int'(status), 0);

    // Back to mid, then a 3-cycle glitch on the high probe.
    hold(0, 1, 0, 15);
    hold(1, 1, 0, 3);
    hold(0, 1, 0, 15);
    check("glitch_status", int'(status), 1);
    check("glitch_count", int'(change_count), 3);

    // Inconsistent pair from the full state.
    hold(1, 1, 0, 15);
    hold(1, 0, 0, 20);
    check("flt_status", int'(status), 3);
    check("flt_fault", int'(fault), 1);
    hold(1, 0, 1, 3);
    check("flt_clr_fault", int'(fault), 1);
    check("flt_clr_status", int'(status), 3);
    hold(1, 1, 0, 20);
`ifdef FAULT_LATCH_EN
    check("latched_status", int'(status), 3);
    check("latched_fault", int'(fault), 1);
`else
    check("recover_status", int'(status), 0);
    check("recover_fault", int'(fault), 0);
`endif
    hold(1, 1, 1, 1);
    hold(1, 1, 0, 5);
    check("cleared_status", int'(status), 0);
    check("cleared_fault", int'(fault), 0);

    // Randomized probe activity with random hold lengths and clears.
    for (int i = 0; i < 60; i++) begin
      bit h, l, c;
      h = 1'($urandom % 2);
      l = 1'($urandom % 2);
      c = ($urandom % 4) == 0;
      hold(h, l, c, int'($urandom_range(1, 14)));
    end

    // Counter wrap: 300 toggles of the low probe from a fresh reset.
    apply_reset();
    hold(0, 0, 0, 8);
    for (int i = 0; i < 300; i++) hold(0, (i % 2) == 0, 0, 10);
    hold(0, 0, 0, 10);
    check("wrap_count", int'(change_count), 300 % 256);

    // Reset in the middle of a debounce run.
    hold(0, 1, 0, 3);
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      bit h, l;
      h = 1'($urandom % 2);
      l = 1'($urandom % 2);
      hold(h, l, 1'b0, int'($urandom_range(1, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
